// File: rtl/key_pkg.sv
// Shared definitions for the key bank: channel FSM states and timer sizing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } key_state_t;

  // Timer must hold the largest terminal count of any of its uses.
  function automatic int unsigned key_tmr_w(input int unsigned dbn,
                                            input int unsigned dly,
                                            input int unsigned per);
    int unsigned m;
    m = dbn;
    if (dly > m) m = dly;
    if (per > m) m = per;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, debounce/repeat FSM and wrapping event counter.
module key_chan
  import key_pkg::*;
#(
  parameter int          KEY_ACT_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int          REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 5000000,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key,
  input  logic             cnt_clr,
  output logic             key_level,
  output logic             key_press,
  output logic             key_release,
  output logic             key_repeat,
  output logic [CNT_W-1:0] key_cnt
);

  localparam int unsigned TMR_W = key_tmr_w(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DLY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PER - 1);
  localparam logic ACT_LOW = (KEY_ACT_LOW != 0);
  localparam logic REP_ON  = (REPEAT_EN != 0);

  logic             sync1;
  logic             sync2;
  logic             p;
  key_state_t       state;
  logic [TMR_W-1:0] dtmr;
  logic [TMR_W-1:0] rtmr;
  logic             rep_ph;

  // Released pin level is the reset value so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACT_LOW;
      sync2 <= ACT_LOW;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ ACT_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dtmr        <= '0;
      rtmr        <= '0;
      rep_ph      <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      key_cnt     <= '0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      if (cnt_clr) key_cnt <= '0;
      case (state)
        IDLE: begin
          if (p) begin
            state <= PCHK;
            dtmr  <= TMR_ONE;
          end
        end
        PCHK: begin
          if (!p) begin
            state <= IDLE;
          end else if (dtmr == DB_LAST) begin
            state     <= HELD;
            key_press <= 1'b1;
            key_level <= 1'b1;
            rtmr      <= '0;
            rep_ph    <= 1'b0;
            if (!cnt_clr) key_cnt <= key_cnt + 1'b1;
          end else begin
            dtmr <= dtmr + 1'b1;
          end
        end
        HELD: begin
          if (!p) begin
            state <= RCHK;
            dtmr  <= TMR_ONE;
          end else if (REP_ON) begin
            // First repeat waits the initial delay, later ones the period.
            if (rtmr == (rep_ph ? PER_LAST : DLY_LAST)) begin
              key_repeat <= 1'b1;
              rtmr       <= '0;
              rep_ph     <= 1'b1;
              if (!cnt_clr) key_cnt <= key_cnt + 1'b1;
            end else begin
              rtmr <= rtmr + 1'b1;
            end
          end
        end
        RCHK: begin
          if (p) begin
            state <= HELD;
          end else if (dtmr == DB_LAST) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            dtmr <= dtmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_bank_ctrl.sv
// N-channel push-button front end: one independent key_chan per key pin.
module key_bank_ctrl
  import key_pkg::*;
#(
  parameter int          NUM_KEYS     = 4,
  parameter int          KEY_ACT_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int          REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 5000000,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_KEYS-1:0]       key,
  input  logic [NUM_KEYS-1:0]       cnt_clr,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       key_press,
  output logic [NUM_KEYS-1:0]       key_release,
  output logic [NUM_KEYS-1:0]       key_repeat,
  output logic [NUM_KEYS*CNT_W-1:0] key_cnt
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_chan #(
      .KEY_ACT_LOW (KEY_ACT_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .cnt_clr    (cnt_clr[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i]),
      .key_cnt    (key_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule
